// File: rtl/half_adder_bist_pkg.sv
// Shared types and constants for the half-adder self-test engine.
package half_adder_bist_pkg;

  localparam int NUM_VEC = 4;
  localparam int VEC_W   = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/half_adder_b.sv
// Combinational 1-bit half adder; used as the golden reference inside the BIST.
module half_adder_b (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b;
  assign cout = a & b;

endmodule

// File: rtl/half_adder_bist.sv
// Self-test engine: walks {a,b} through 00..11, compares the external adder
// against a golden half adder and reports per-vector failures and a pass flag.
module half_adder_bist
  import half_adder_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sum,
  input  logic             cout,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       fail_vec
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

  state_t           state_q, state_d;
  logic             a_q, a_d, b_q, b_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       fail_q, fail_d;
  logic             exp_sum, exp_cout, mismatch;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  half_adder_b u_golden (
    .a    (a_q),
    .b    (b_q),
    .sum  (exp_sum),
    .cout (exp_cout)
  );

  // A vector counts once even when both outputs are wrong.
  assign mismatch = (sum != exp_sum) || (cout != exp_cout);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT;
          a_d     = 1'b0;
          b_d     = 1'b0;
          vec_d   = '0;
          cnt_d   = RELOAD;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = CHECK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      CHECK: begin
        if (mismatch) begin
          fail_d[vec_q] = 1'b1;
          err_d         = sat_inc(err_q);
        end
        if (vec_q == LAST_VEC) begin
          // pass is decided here so it is valid together with the done pulse.
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (err_q == '0) && !mismatch;
        end else begin
          state_d    = WAIT;
          vec_d      = vec_q + VEC_W'(1);
          {a_d, b_d} = vec_q + VEC_W'(1);
          cnt_d      = RELOAD;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_vec = fail_q;

endmodule

// File: tb/tb_half_adder_bist.sv
// Bench for half_adder_bist: two engines (ERR_W=3 and ERR_W=2) watch a faultable adder model.
module tb_half_adder_bist;

  localparam int S   = 4;
  localparam int RUN = 4 * (S + 1);

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [3:0] flip_s, flip_c;

  logic       a0, b0, busy0, done0, pass0, sum0, cout0;
  logic [2:0] err0;
  logic [3:0] fv0;
  logic       a1, b1, busy1, done1, pass1, sum1, cout1;
  logic [1:0] err1;
  logic [3:0] fv1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Adder under test: correct half adder with per-vector output flips.
  assign sum0  = (a0 ^ b0) ^ flip_s[{a0, b0}];
  assign cout0 = (a0 & b0) ^ flip_c[{a0, b0}];
  assign sum1  = (a1 ^ b1) ^ flip_s[{a1, b1}];
  assign cout1 = (a1 & b1) ^ flip_c[{a1, b1}];

  half_adder_bist #(.SETTLE_CYCLES(S), .ERR_W(3)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .sum(sum0), .cout(cout0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_vec(fv0)
  );

  half_adder_bist #(.SETTLE_CYCLES(S), .ERR_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sum(sum1), .cout(cout1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_vec(fv1)
  );

  // One full run from start acceptance to the first IDLE cycle, checked every cycle.
  task automatic do_run(input string name, input bit pulses, input bit hold);
    logic [11:0] got0, exp0;
    logic [10:0] got1, exp1;
    logic [3:0]  fv;
    logic [1:0]  eab;
    int          chk, cnt;
    start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k <= RUN + 1; k++) begin
      chk = (k / (S + 1) > 4) ? 4 : k / (S + 1);
      cnt = 0;
      fv  = 4'b0000;
      for (int i = 0; i < chk; i++)
        if (flip_s[i] || flip_c[i]) begin
          cnt++;
          fv[i] = 1'b1;
        end
      eab  = (k >= RUN) ? 2'b11 : 2'(k / (S + 1));
      exp0 = {eab, (k <= RUN), (k == RUN), (k >= RUN && cnt == 0),
              3'((cnt > 7) ? 7 : cnt), fv};
      exp1 = {eab, (k <= RUN), (k == RUN), (k >= RUN && cnt == 0),
              2'((cnt > 3) ? 3 : cnt), fv};
      got0 = {a0, b0, busy0, done0, pass0, err0, fv0};
      got1 = {a1, b1, busy1, done1, pass1, err1, fv1};
      n_vec++;
      if (got0 !== exp0) begin
        n_err++;
        $display("FAIL %s err_w3 k=%0d {a,b,busy,done,pass,err,fv} got %b want %b",
                 name, k, got0, exp0);
      end
      n_vec++;
      if (got1 !== exp1) begin
        n_err++;
        $display("FAIL %s err_w2 k=%0d {a,b,busy,done,pass,err,fv} got %b want %b",
                 name, k, got1, exp1);
      end
      start = hold ? 1'b1 : (pulses && (k == 2 || k == 14));
      if (k <= RUN) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b1;
    start  = 1'b0;
    flip_s = 4'b0000;
    flip_c = 4'b0000;
    #3 rst_n = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if ({a0, b0, busy0, done0, pass0, err0, fv0, a1, b1, busy1, done1, pass1, err1, fv1} !== '0) begin
        n_err++;
        $display("FAIL reset c=%0d outputs got %b want all zero", c,
                 {a0, b0, busy0, done0, pass0, err0, fv0, a1, b1, busy1, done1, pass1, err1, fv1});
      end
      @(posedge clk); #1;
      if (c == 1) rst_n = 1'b1;
    end
  endtask

  task automatic test_clean_run();
    flip_s = 4'b0000;
    flip_c = 4'b0000;
    do_run("clean", 1'b0, 1'b0);
  endtask

  task automatic test_cout_stuck();
    flip_s = 4'b0000;
    flip_c = 4'b1000;
    do_run("cout_stuck0", 1'b0, 1'b0);
  endtask

  task automatic test_sum_inverted();
    flip_s = 4'b1111;
    flip_c = 4'b0000;
    do_run("sum_inv", 1'b0, 1'b0);
  endtask

  task automatic test_ignored_start();
    flip_s = 4'b0000;
    flip_c = 4'b0000;
    do_run("extra_start", 1'b1, 1'b0);
  endtask

  task automatic test_mid_run_reset();
    flip_s = 4'b0110;
    flip_c = 4'b0001;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    n_vec++;
    if ({a0, b0, busy0, done0} !== 4'b1010) begin
      n_err++;
      $display("FAIL midreset_pre {a,b,busy,done} got %b want 1010", {a0, b0, busy0, done0});
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({a0, b0, busy0, done0, pass0, err0, fv0, a1, b1, busy1, done1, pass1, err1, fv1} !== '0) begin
      n_err++;
      $display("FAIL midreset_async outputs got %b want all zero",
               {a0, b0, busy0, done0, pass0, err0, fv0, a1, b1, busy1, done1, pass1, err1, fv1});
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < RUN + 4; c++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({busy0, done0, busy1, done1} !== 4'b0000) begin
        n_err++;
        $display("FAIL midreset_nodone c=%0d {busy0,done0,busy1,done1} got %b want 0000",
                 c, {busy0, done0, busy1, done1});
      end
    end
    flip_s = 4'b0000;
    flip_c = 4'b0000;
    do_run("after_reset", 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    flip_s = 4'b0000;
    flip_c = 4'b1000;
    do_run("b2b_faulty", 1'b0, 1'b1);
    flip_c = 4'b0000;
    do_run("b2b_clean", 1'b0, 1'b1);
    start = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      flip_s = 4'($urandom);
      flip_c = 4'($urandom);
      do_run("random", 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_cout_stuck();
    test_sum_inverted();
    test_ignored_start();
    test_mid_run_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
